// File: rtl/osc_acq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : osc_acq_ctrl_if
//  Description : Sample-stream, trigger-control and capture-RAM write bundle
//                for the oscilloscope acquisition sequencer.
//                Optional macro OSC_PRETRIG_EN adds the trig_addr status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface osc_acq_ctrl_if #(
    parameter int SAMPLE_W = 8,
    parameter int LEVEL_W  = 6,
    parameter int ADDR_W   = 9
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic [LEVEL_W-1:0]  level;
    logic                slope;
    logic                mode;
    logic [1:0]          time_per_div;
    logic                disp_vsync;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                wr_bank;
    logic                disp_bank;
    logic                frame_ready;
    logic                triggered;
    logic                auto_fired;
`ifdef OSC_PRETRIG_EN
    logic [ADDR_W-1:0]   trig_addr;

    modport master (
        output sample_valid, sample, level, slope, mode, time_per_div, disp_vsync,
        input  wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_ready,
               triggered, auto_fired, trig_addr
    );
    modport slave (
        input  sample_valid, sample, level, slope, mode, time_per_div, disp_vsync,
        output wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_ready,
               triggered, auto_fired, trig_addr
    );
`else
    modport master (
        output sample_valid, sample, level, slope, mode, time_per_div, disp_vsync,
        input  wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_ready,
               triggered, auto_fired
    );
    modport slave (
        input  sample_valid, sample, level, slope, mode, time_per_div, disp_vsync,
        output wr_en, wr_addr, wr_data, wr_bank, disp_bank, frame_ready,
               triggered, auto_fired
    );
`endif
endinterface
`default_nettype wire

// File: rtl/osc_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : osc_acq_ctrl
//  Description : Oscilloscope acquisition sequencer. Decimates the ADC stream,
//                detects level/slope triggers (with auto timeout), captures
//                one frame into the write bank of a ping-pong RAM and swaps
//                banks with the display on vertical sync.
//                Optional macro OSC_PRETRIG_EN: circular pre-trigger capture
//                with half-depth history and a trig_addr status output.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_acq_ctrl #(
    parameter int SAMPLE_W     = 8,
    parameter int LEVEL_W      = 6,
    parameter int ADDR_W       = 9,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    osc_acq_ctrl_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PAD_W = SAMPLE_W - LEVEL_W;
    localparam int TMO_W = $clog2(AUTO_TIMEOUT) + 1;
`ifdef OSC_PRETRIG_EN
    localparam logic [ADDR_W-1:0] c_post_writes = ADDR_W'(DEPTH / 2);
`else
    localparam logic [ADDR_W-1:0] c_post_writes = ADDR_W'(DEPTH - 1);
`endif

    localparam logic [1:0] S_ARM  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [5:0]          r_dec_cnt;
    logic [5:0]          r_dec_max;     // decimation factor minus one
    logic [SAMPLE_W-1:0] r_prev;
    logic                r_prev_valid;
    logic [TMO_W-1:0]    r_tmo_cnt;     // saturates at AUTO_TIMEOUT-1
    logic [ADDR_W-1:0]   r_ptr;         // next write address
    logic [ADDR_W-1:0]   r_remain;      // writes still owed in CAPTURE

    logic                w_taken;
    logic [SAMPLE_W-1:0] w_level;
    logic                w_rise;
    logic                w_fall;
    logic                w_hit;
    logic                w_force;
    logic                w_trig;
    logic                w_last;
    logic                w_write;
    logic [ADDR_W-1:0]   w_addr;

    assign w_taken = bus.sample_valid && (r_dec_cnt == 6'd0);
    assign w_level = SAMPLE_W'(bus.level) << PAD_W;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_ARM;
        else      r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ARM:   w_next_state = S_WAIT;
            S_WAIT:  if (w_trig) w_next_state = S_CAP;
            S_CAP:   if (w_last) w_next_state = S_HOLD;
            S_HOLD:  if (bus.disp_vsync) w_next_state = S_ARM;
            default: w_next_state = S_ARM;
        endcase
    end

    // Trigger detection and write-strobe decode
    always_comb begin
        w_rise  = r_prev_valid && (r_prev < w_level) && (bus.sample >= w_level);
        w_fall  = r_prev_valid && (r_prev >= w_level) && (bus.sample < w_level);
        w_hit   = bus.slope ? w_fall : w_rise;
        w_force = bus.mode && !w_hit && (r_tmo_cnt == TMO_W'(AUTO_TIMEOUT - 1));
        w_trig  = (r_state == S_WAIT) && w_taken && (w_hit || w_force);
        w_last  = (r_state == S_CAP) && w_taken && (r_remain == ADDR_W'(1));
`ifdef OSC_PRETRIG_EN
        w_write = w_taken && ((r_state == S_WAIT) || (r_state == S_CAP));
        w_addr  = r_ptr;
`else
        w_write = w_trig || ((r_state == S_CAP) && w_taken);
        w_addr  = w_trig ? '0 : r_ptr;
`endif
    end

    // Datapath: decimation, trigger history, RAM writes, bank handoff
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dec_cnt        <= '0;
            r_dec_max        <= '0;
            r_prev           <= '0;
            r_prev_valid     <= 1'b0;
            r_tmo_cnt        <= '0;
            r_ptr            <= '0;
            r_remain         <= '0;
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_data      <= '0;
            bus.wr_bank      <= 1'b0;
            bus.disp_bank    <= 1'b1;
            bus.frame_ready  <= 1'b0;
            bus.triggered    <= 1'b0;
            bus.auto_fired   <= 1'b0;
`ifdef OSC_PRETRIG_EN
            bus.trig_addr    <= '0;
`endif
        end else begin
            bus.wr_en <= w_write;
            if (w_write) begin
                bus.wr_addr <= w_addr;
                bus.wr_data <= bus.sample;
                r_ptr       <= w_addr + ADDR_W'(1);
            end
            if (bus.sample_valid)
                r_dec_cnt <= (r_dec_cnt >= r_dec_max) ? 6'd0 : r_dec_cnt + 6'd1;

            case (r_state)
                S_ARM: begin
                    r_prev_valid   <= 1'b0;
                    r_tmo_cnt      <= '0;
                    r_ptr          <= '0;
                    bus.auto_fired <= 1'b0;
                    case (bus.time_per_div)
                        2'd0:    r_dec_max <= 6'd0;
                        2'd1:    r_dec_max <= 6'd3;
                        2'd2:    r_dec_max <= 6'd15;
                        default: r_dec_max <= 6'd63;
                    endcase
                end
                S_WAIT: begin
                    if (w_taken) begin
                        r_prev       <= bus.sample;
                        r_prev_valid <= 1'b1;
                        if (!w_trig && (r_tmo_cnt != TMO_W'(AUTO_TIMEOUT - 1)))
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                    if (w_trig) begin
                        bus.triggered  <= 1'b1;
                        bus.auto_fired <= w_force;
                        r_remain       <= c_post_writes;
`ifdef OSC_PRETRIG_EN
                        bus.trig_addr  <= r_ptr;
`endif
                    end
                end
                S_CAP: begin
                    if (w_taken) r_remain <= r_remain - ADDR_W'(1);
                    if (w_last)  bus.frame_ready <= 1'b1;
                end
                default: begin
                    if (bus.disp_vsync) begin
                        bus.disp_bank   <= bus.wr_bank;
                        bus.wr_bank     <= ~bus.wr_bank;
                        bus.frame_ready <= 1'b0;
                        bus.triggered   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_osc_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osc_acq_ctrl
//  Description : Scoreboard bench for osc_acq_ctrl with a behavioural model
//                of the acquisition rules and randomized sample streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_acq_ctrl;
    localparam int SAMPLE_W     = 8;
    localparam int LEVEL_W      = 6;
    localparam int ADDR_W       = 9;
    localparam int AUTO_TIMEOUT = 1024;
    localparam int DEPTH        = 2 ** ADDR_W;
`ifdef OSC_PRETRIG_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif
    localparam int ST_ARM = 0, ST_WAIT = 1, ST_CAP = 2, ST_HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    osc_acq_ctrl_if #(.SAMPLE_W(SAMPLE_W), .LEVEL_W(LEVEL_W), .ADDR_W(ADDR_W)) bus ();

    osc_acq_ctrl #(
        .SAMPLE_W(SAMPLE_W), .LEVEL_W(LEVEL_W), .ADDR_W(ADDR_W), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct { int addr; int data; int bank; } wr_t;
    wr_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_pulses = 0;

    // Reference model state
    int m_state = ST_ARM, m_phase = 0, m_factor = 1, m_prev = 0, m_seen = 0;
    int m_ptr = 0, m_post = 0, m_bank = 0, m_disp = 1, m_ready = 0, m_trig = 0;
    int m_auto = 0, m_taddr = 0;
    bit m_pv = 0;

    task automatic push_wr(input int addr, input int data);
        wr_t e;
        e.addr = addr; e.data = data; e.bank = m_bank;
        exp_q.push_back(e);
    endtask

    // Effect of one clock edge on the acquisition model
    task automatic model_edge();
        bit taken, hit, frc;
        int s, lv;
        if (!rst) begin
            m_state = ST_ARM; m_phase = 0; m_factor = 1; m_pv = 0; m_seen = 0;
            m_ptr = 0; m_post = 0; m_bank = 0; m_disp = 1; m_ready = 0;
            m_trig = 0; m_auto = 0; m_taddr = 0;
            return;
        end
        s  = int'(bus.sample);
        lv = int'(bus.level) * (2 ** (SAMPLE_W - LEVEL_W));
        taken = bus.sample_valid && (m_phase == 0);
        if (bus.sample_valid) m_phase = (m_phase >= m_factor - 1) ? 0 : m_phase + 1;
        case (m_state)
            ST_ARM: begin
                m_pv = 0; m_seen = 0; m_auto = 0; m_ptr = 0;
                m_factor = 1 << (2 * int'(bus.time_per_div));
                m_state = ST_WAIT;
            end
            ST_WAIT: if (taken) begin
                hit = m_pv && (bus.slope ? (m_prev >= lv && s < lv) : (m_prev < lv && s >= lv));
                frc = !hit && bus.mode && (m_seen >= AUTO_TIMEOUT - 1);
                m_prev = s; m_pv = 1; m_seen++;
                if (hit || frc) begin
                    m_auto = frc; m_trig = 1; m_post = 0; m_state = ST_CAP;
                    if (PRE) begin
                        m_taddr = m_ptr; push_wr(m_ptr, s); m_ptr = (m_ptr + 1) % DEPTH;
                    end else begin
                        push_wr(0, s); m_ptr = 1;
                    end
                end else if (PRE) begin
                    push_wr(m_ptr, s); m_ptr = (m_ptr + 1) % DEPTH;
                end
            end
            ST_CAP: if (taken) begin
                push_wr(m_ptr, s); m_ptr = (m_ptr + 1) % DEPTH; m_post++;
                if (m_post == (PRE ? DEPTH / 2 : DEPTH - 1)) begin
                    m_ready = 1; m_state = ST_HOLD;
                end
            end
            default: if (bus.disp_vsync) begin
                m_disp = m_bank; m_bank = 1 - m_bank; m_ready = 0; m_trig = 0;
                m_state = ST_ARM;
            end
        endcase
    endtask

    // Monitor: pops the expected write on every wr_en, checks status each cycle
    always @(negedge clk) begin
        wr_t e;
        if (bus.wr_en === 1'b1) begin
            wr_pulses++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%0d data=%0d, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr !== ADDR_W'(e.addr) || bus.wr_data !== SAMPLE_W'(e.data) ||
                    bus.wr_bank !== e.bank[0]) begin
                    n_fail++;
                    $display("FAIL wr_content: got addr=%0d data=%0d bank=%0d, required addr=%0d data=%0d bank=%0d",
                             bus.wr_addr, bus.wr_data, bus.wr_bank, e.addr, e.data, e.bank);
                end
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL wr_missing: got wr_en=%b, required write addr=%0d data=%0d",
                     bus.wr_en, e.addr, e.data);
        end
        n_tests++;
        if (bus.wr_bank !== m_bank[0] || bus.disp_bank !== m_disp[0] ||
            bus.frame_ready !== m_ready[0] || bus.triggered !== m_trig[0] ||
            bus.auto_fired !== m_auto[0] || bus.wr_bank === bus.disp_bank
`ifdef OSC_PRETRIG_EN
            || bus.trig_addr !== ADDR_W'(m_taddr)
`endif
            ) begin
            n_fail++;
            $display("FAIL status @%0t: got wb=%b db=%b fr=%b tr=%b af=%b, required wb=%0d db=%0d fr=%0d tr=%0d af=%0d",
                     $time, bus.wr_bank, bus.disp_bank, bus.frame_ready, bus.triggered,
                     bus.auto_fired, m_bank, m_disp, m_ready, m_trig, m_auto);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input int s, input bit vs);
        bus.sample_valid = v;
        bus.sample       = s[SAMPLE_W-1:0];
        bus.disp_vsync   = vs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.disp_vsync   = 1'b0;
    endtask

    // Reset for one edge, then the ARM cycle with no strobe
    task automatic do_reset();
        rst = 1'b0;
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic run_samples(input int n, input int val);
        for (int i = 0; i < n; i++) step(1, (val < 0) ? int'($urandom_range(0, 255)) : val, 0);
    endtask

    int base;

    initial begin
        bus.sample_valid = 0; bus.sample = '0; bus.level = 6'd32; bus.slope = 0;
        bus.mode = 0; bus.time_per_div = 2'd0; bus.disp_vsync = 0;
        @(negedge clk);
        do_reset();
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        check("reset_wr_data", bus.wr_data, 0);
        check("reset_disp_bank", bus.disp_bank, 1);

        // Rising ramp: 120 is first sample and never triggers, 128 triggers
        for (int v = 120; v <= 136; v += 4) begin
            step(1, v, 0);
            if (v == 124) check("rise_no_trig_124", bus.triggered, 0);
            if (v == 128) begin
                check("rise_trig_data", bus.wr_data, 128);
                check("rise_trig_addr", bus.wr_addr, PRE ? 2 : 0);
            end
        end
        run_samples(DEPTH, -1);
        step(0, 0, 1);
        check("swap1_disp_bank", bus.disp_bank, 0);

        // Capture partly, then reset mid-CAPTURE
        step(0, 0, 0);
        run_samples(2, 200);
        run_samples(1, 100);
        run_samples(1, 200);
        run_samples(100, -1);
        rst = 1'b0;
        step(1, 50, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_wr_addr", bus.wr_addr, 0);
        check("midrst_wr_bank", bus.wr_bank, 0);
        check("midrst_frame_ready", bus.frame_ready, 0);
        rst = 1'b1;
        step(0, 0, 0);

        // Falling slope
        bus.slope = 1;
        do_reset();
        step(1, 127, 0);
        step(1, 126, 0);
        check("fall_no_trig", bus.triggered, 0);
        step(1, 140, 0);
        step(1, 130, 0);
        step(1, 127, 0);
        check("fall_trig_data", bus.wr_data, 127);
        check("fall_triggered", bus.triggered, 1);
        run_samples(DEPTH, -1);
        step(0, 0, 1);

        // Auto mode forces a trigger on the 1024th taken sample
        bus.slope = 0; bus.mode = 1;
        do_reset();
        run_samples(AUTO_TIMEOUT - 1, 10);
        check("auto_not_yet", bus.triggered, 0);
        run_samples(1, 10);
        check("auto_triggered", bus.triggered, 1);
        check("auto_fired", bus.auto_fired, 1);
        run_samples(DEPTH, 10);
        check("auto_frame_ready", bus.frame_ready, 1);

        // Normal mode waits forever; vsync outside HOLD is ignored
        bus.mode = 0;
        do_reset();
        base = wr_pulses;
        run_samples(5000, 10);
        check("normal_no_trig", bus.triggered, 0);
        check("normal_writes", wr_pulses - base, PRE ? 5000 : 0);
        step(0, 0, 1);
        check("vsync_wait_disp", bus.disp_bank, 1);
        check("vsync_wait_wr", bus.wr_bank, 0);

        // Decimation by 16, full frame, HOLD retained, then swap
        bus.time_per_div = 2'd2;
        do_reset();
        base = wr_pulses;
        for (int i = 0; i < 16 * DEPTH + 16; i++)
            step(1, (i < 16) ? 0 : ((i == 16) ? 255 : int'($urandom_range(0, 255))), 0);
        check("dec16_writes", wr_pulses - base, PRE ? 2 + DEPTH / 2 : DEPTH);
        check("dec16_frame_ready", bus.frame_ready, 1);
        base = wr_pulses;
        run_samples(2000, -1);
        check("hold_no_writes", wr_pulses - base, 0);
        check("hold_retained", bus.frame_ready, 1);
        step(0, 0, 1);
        check("swap_disp_bank", bus.disp_bank, 0);
        check("swap_wr_bank", bus.wr_bank, 1);
        check("swap_frame_ready", bus.frame_ready, 0);

        // Randomized streams with random settings and vsync pulses
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            bus.level = 6'($urandom_range(0, 63));
            bus.slope = 1'($urandom_range(0, 1));
            bus.mode  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3000; i++) begin
                if (i % 100 == 0) bus.time_per_div = 2'($urandom_range(0, 1));
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                     $urandom_range(0, 63) == 0);
            end
        end
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/osc_acq_ctrl.md
Name: osc_acq_ctrl

Overview:
Acquisition sequencer for the oscilloscope datapath. It sits between the ADC sample stream and the ping-pong capture RAM that the VGA renderer reads. It decimates samples per the time/div setting and detects level/slope triggers, with an auto-trigger timeout. It writes one frame per trigger, then hands the filled bank to the display on the next vertical-sync pulse.

Parameters:
SAMPLE_W, 8, sample width in bits
LEVEL_W, 6, trigger-level switch width; the level compares as {level, (SAMPLE_W-LEVEL_W) zeros}
ADDR_W, 9, capture depth DEPTH = 2**ADDR_W samples per bank
AUTO_TIMEOUT, 1024, taken samples without a trigger before auto mode forces one

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
sample_valid  in  1  one-cycle strobe, new ADC sample present
sample  in  SAMPLE_W  unsigned ADC sample
level  in  LEVEL_W  trigger level
slope  in  1  0 = rising, 1 = falling
mode  in  1  0 = normal (wait forever), 1 = auto (timeout)
time_per_div  in  2  decimation select: 0→1, 1→4, 2→16, 3→64
disp_vsync  in  1  one-cycle pulse at display frame start
wr_en  out  1  capture RAM write strobe
wr_addr  out  ADDR_W  capture RAM address
wr_data  out  SAMPLE_W  capture RAM data
wr_bank  out  1  bank being written
disp_bank  out  1  bank the display reads
frame_ready  out  1  wr_bank holds a complete frame awaiting swap
triggered  out  1  status: capture in progress or held
auto_fired  out  1  current/held frame was forced by timeout

Behaviour:
- Reset (rst==0 at a clk edge) takes effect that edge from any state, including mid-capture.
- Reset values: state=ARM, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, disp_bank=1, frame_ready=0, triggered=0, auto_fired=0. Decimation, timeout and write counters clear; the prev-sample-valid flag clears.
- Decimation: a counter advances on each sample_valid. A sample is "taken" when sample_valid=1 and the counter==0. The counter wraps at factor-1. time_per_div is sampled in ARM only; changes in other states are ignored until the next ARM.
- States:
  - ARM: one cycle; clear prev flag, timeout counter and auto_fired; latch decimation factor → WAIT_TRIG.
  - WAIT_TRIG, on each taken sample:
    - Rising trigger: prev_valid && prev < L && sample >= L.
    - Falling trigger: prev_valid && prev >= L && sample < L.
    - Then prev <= sample and prev_valid <= 1.
    - The first taken sample after ARM never triggers.
    - If mode=1 and the timeout counter reaches AUTO_TIMEOUT-1 without a trigger: force a trigger on that sample and set auto_fired=1.
    - On a trigger (real or forced) that same sample is written at addr 0 → CAPTURE.
  - CAPTURE: each taken sample is written at the next address. After the write to addr DEPTH-1 → HOLD and set frame_ready=1. triggered=1 in CAPTURE and HOLD.
  - HOLD: samples ignored. On disp_vsync=1: disp_bank<=wr_bank, wr_bank<=~wr_bank, frame_ready<=0, triggered<=0 → ARM. A vsync in any other state is ignored.
- Write timing: wr_en, wr_addr and wr_data are registered one cycle after the taken sample. wr_en is a single-cycle pulse. wr_addr wraps modulo DEPTH.
- Invariant: wr_bank != disp_bank at all times.
- Level comparisons are unsigned on SAMPLE_W bits.

Optional Feature:
OSC_PRETRIG_EN:
- Defined:
  - WAIT_TRIG writes every taken sample circularly to wr_bank.
  - Adds output trig_addr (ADDR_W), the address of the trigger sample.
  - CAPTURE continues until DEPTH/2 further samples are written after the trigger, giving half-depth pre-trigger history.
  - If fewer than DEPTH/2 samples were written before the trigger, the unwritten locations are undefined.
  - trig_addr resets to 0.
- Undefined: no writes in WAIT_TRIG; the trigger sample sits at addr 0; trig_addr is absent.

Test Plan:
- rst=0 mid-CAPTURE at addr 100 → next cycle: wr_en=0, wr_addr=0, wr_bank=0, disp_bank=1, frame_ready=0, state ARM.
- level=32 (L=128), slope=0, tpd=0, ramp 120,124,...,136 → trigger on 128, wr_addr=0 wr_data=128 one cycle later; 120 never triggers as first sample.
- slope=1, level=32, samples 140,130,127 → trigger on 127; samples 127,126 after ARM → no trigger.
- mode=1, constant sample=10, level=32, tpd=0 → forced trigger on the 1024th taken sample, auto_fired=1; mode=0 same stimulus → stays in WAIT_TRIG for 5000 samples.
- tpd=2, trigger then 16*512 sample_valid strobes → exactly 512 wr_en pulses, frame_ready=1; disp_vsync → disp_bank=0, wr_bank=1, frame_ready=0.
- Frame complete, no vsync for 2000 samples → no wr_en, HOLD retained; vsync pulse during WAIT_TRIG → no bank change.
